// File: rtl/sd_spi.sv
// SPI mode-0 byte shifter for an SD card: MSB first, 8 bits per transfer,
// sdclk derived from fclk by a programmable half-period divider.
module sd_spi #(
    parameter int unsigned CLKDIV = 2
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       sdclk,
    output logic       sddo,
    input  logic       sddi
);

    localparam logic [7:0] DivLast = 8'(CLKDIV - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] dout_q, dout_d;
    logic       sdclk_q, sdclk_d;
    logic       sddo_q, sddo_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 8'hFF;
            rx_q    <= '0;
            dout_q  <= 8'hFF;
            sdclk_q <= 1'b0;
            sddo_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            sdclk_q <= sdclk_d;
            sddo_q  <= sddo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        sdclk_d = sdclk_q;
        sddo_d  = sddo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                sdclk_d = 1'b0;
                if (start) begin
                    state_d = StShift;
                    tx_d    = din;
                    sddo_d  = din[7];
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    sdclk_d = ~sdclk_q;
                    // Falling edge: capture MISO and advance MOSI together.
                    if (sdclk_q) begin
                        rx_d   = {rx_q[6:0], sddi};
                        tx_d   = {tx_q[6:0], 1'b1};
                        sddo_d = tx_q[6];
                        bit_d  = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = StIdle;
                            dout_d  = {rx_q[6:0], sddi};
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            sddo_d  = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dout  = dout_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sdclk = sdclk_q;
    assign sddo  = sddo_q;

endmodule

// File: tb/tb_sd_spi.sv
// Directed bench for sd_spi: one instance at CLKDIV=2, one at CLKDIV=1,
// with a bench-side SPI slave that plays back a chosen MISO byte.
module tb_sd_spi;

    logic       fclk;
    logic       rst_n;
    logic       start_a, start_b;
    logic [7:0] din_a, din_b;
    logic [7:0] dout_a, dout_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic       sdclk_a, sdclk_b, sddo_a, sddo_b;
    logic       sddi_a, sddi_b;

    int checks = 0;
    int errors = 0;

    sd_spi #(.CLKDIV(2)) dut_a (
        .fclk(fclk), .rst_n(rst_n), .start(start_a), .din(din_a), .dout(dout_a),
        .busy(busy_a), .done(done_a), .sdclk(sdclk_a), .sddo(sddo_a), .sddi(sddi_a)
    );

    sd_spi #(.CLKDIV(1)) dut_b (
        .fclk(fclk), .rst_n(rst_n), .start(start_b), .din(din_b), .dout(dout_b),
        .busy(busy_b), .done(done_b), .sdclk(sdclk_b), .sddo(sddo_b), .sddi(sddi_b)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    typedef struct {
        logic [7:0] din;
        logic [7:0] miso;
        logic [7:0] exp_mosi;
        logic [7:0] exp_dout;
    } vec_t;

    // Results of the most recent run_xfer
    logic [7:0] got_mosi, got_dout;
    int nrise, nbusy, ndone, nbadph, nruns, nidleclk;
    bit seen_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input bit w, input logic s, input logic [7:0] d);
        if (w) begin start_b = s; din_b = d; end
        else begin start_a = s; din_a = d; end
    endtask

    task automatic set_sddi(input bit w, input logic v);
        if (w) sddi_b = v;
        else sddi_a = v;
    endtask

    // Issue one transfer and observe it cycle by cycle, #1 after each edge.
    task automatic run_xfer(input bit w, input logic [7:0] d, input logic [7:0] m,
                            input int inj, input bit chain, input int cdiv);
        int idx, run_len, post;
        logic prev_clk, run_val, cb, cs, cd, co;
        got_mosi = '0; got_dout = '0;
        nrise = 0; nbusy = 0; ndone = 0; nbadph = 0; nruns = 0; nidleclk = 0;
        seen_done = 0; idx = 0; run_len = 0; run_val = 0; post = 0; prev_clk = 0;
        set_sddi(w, m[7]);
        set_start(w, 1'b1, d);
        @(posedge fclk); #1;
        set_start(w, 1'b0, 8'hFF);
        for (int c = 0; c < 200; c++) begin
            cb = w ? busy_b : busy_a;
            cs = w ? sdclk_b : sdclk_a;
            cd = w ? done_b : done_a;
            co = w ? sddo_b : sddo_a;
            if (cb) begin
                nbusy++;
                if (run_len > 0 && cs != run_val) begin
                    if (run_len != cdiv) nbadph++;
                    nruns++;
                    run_len = 0;
                end
                run_val = cs;
                run_len++;
            end else begin
                if (cs) nidleclk++;
                if (run_len > 0) begin
                    if (run_len != cdiv) nbadph++;
                    nruns++;
                    run_len = 0;
                end
            end
            if (cs && !prev_clk) begin
                got_mosi = {got_mosi[6:0], co};
                nrise++;
            end
            if (!cs && prev_clk) begin
                idx++;
                if (idx < 8) set_sddi(w, m[7-idx]);
            end
            prev_clk = cs;
            if (cd) begin
                ndone++;
                if (!seen_done) got_dout = w ? dout_b : dout_a;
                seen_done = 1;
                if (chain) begin
                    set_start(w, 1'b1, 8'hFF);
                    set_sddi(w, 1'b1);
                    return;
                end
            end
            if (c == inj) set_start(w, 1'b1, 8'h00);
            else if (c == inj + 1) set_start(w, 1'b0, 8'hFF);
            if (seen_done) post++;
            if (post > 3) break;
            @(posedge fclk); #1;
        end
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] exp_mosi,
                              input logic [7:0] exp_dout, input int cdiv);
        chk({tag, " done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " mosi"}, 32'(got_mosi), 32'(exp_mosi));
        chk({tag, " dout"}, 32'(got_dout), 32'(exp_dout));
        chk({tag, " busy_cycles"}, nbusy, 16 * cdiv);
        chk({tag, " sdclk_rises"}, nrise, 8);
        chk({tag, " sdclk_phases"}, nruns, 16);
        chk({tag, " bad_phase_len"}, nbadph, 0);
        chk({tag, " idle_sdclk_high"}, nidleclk, 0);
    endtask

    vec_t vecs[5];
    int k, nd, nb;

    initial begin
        vecs[0] = '{din: 8'hA5, miso: 8'h3C, exp_mosi: 8'hA5, exp_dout: 8'h3C};
        vecs[1] = '{din: 8'h00, miso: 8'hFF, exp_mosi: 8'h00, exp_dout: 8'hFF};
        vecs[2] = '{din: 8'hFF, miso: 8'h00, exp_mosi: 8'hFF, exp_dout: 8'h00};
        vecs[3] = '{din: 8'h5A, miso: 8'hC3, exp_mosi: 8'h5A, exp_dout: 8'hC3};
        vecs[4] = '{din: 8'h81, miso: 8'h7E, exp_mosi: 8'h81, exp_dout: 8'h7E};

        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; din_a = 8'hFF; din_b = 8'hFF;
        sddi_a = 1'b1; sddi_b = 1'b1;
        repeat (3) @(posedge fclk);
        #1;
        chk("rst dout", 32'(dout_a), 32'hFF);
        chk("rst sdclk", 32'(sdclk_a), 32'h0);
        chk("rst sddo", 32'(sddo_a), 32'h1);
        chk("rst busy", 32'(busy_a), 32'h0);
        chk("rst done", 32'(done_a), 32'h0);
        chk("rst dout_b", 32'(dout_b), 32'hFF);
        rst_n = 1'b1;
        repeat (2) @(posedge fclk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_xfer(1'b0, vecs[i].din, vecs[i].miso, -1, 1'b0, 2);
            check_xfer($sformatf("vec%0d", i), vecs[i].exp_mosi, vecs[i].exp_dout, 2);
        end

        // Start during SHIFT must be ignored
        run_xfer(1'b0, 8'hA5, 8'h3C, 5, 1'b0, 2);
        check_xfer("ignore_start", 8'hA5, 8'h3C, 2);

        // Back-to-back: start presented in the done cycle
        run_xfer(1'b0, 8'hA5, 8'h3C, -1, 1'b1, 2);
        chk("b2b first dout", 32'(got_dout), 32'h3C);
        @(posedge fclk); #1;
        set_start(1'b0, 1'b0, 8'hFF);
        chk("b2b busy next", 32'(busy_a), 32'h1);
        chk("b2b done cleared", 32'(done_a), 32'h0);
        k = 0;
        for (int c = 1; c < 100; c++) begin
            @(posedge fclk); #1;
            if (c == 16) chk("b2b dout stable", 32'(dout_a), 32'h3C);
            if (done_a) begin k = c; break; end
        end
        chk("b2b done cycle", k, 32);
        chk("b2b dout", 32'(dout_a), 32'hFF);
        repeat (2) @(posedge fclk);
        #1;

        // Reset mid-transfer (4th bit), dout previously 0x3C
        run_xfer(1'b0, 8'hA5, 8'h3C, -1, 1'b0, 2);
        chk("pre_rst dout", 32'(got_dout), 32'h3C);
        set_start(1'b0, 1'b1, 8'hA5);
        @(posedge fclk); #1;
        set_start(1'b0, 1'b0, 8'hFF);
        repeat (13) @(posedge fclk);
        #1;
        chk("mid busy before rst", 32'(busy_a), 32'h1);
        rst_n = 1'b0;
        set_start(1'b0, 1'b1, 8'h00);
        @(posedge fclk); #1;
        chk("abort sdclk", 32'(sdclk_a), 32'h0);
        chk("abort sddo", 32'(sddo_a), 32'h1);
        chk("abort busy", 32'(busy_a), 32'h0);
        chk("abort done", 32'(done_a), 32'h0);
        chk("abort dout", 32'(dout_a), 32'hFF);
        rst_n = 1'b1;
        set_start(1'b0, 1'b0, 8'hFF);
        nd = 0; nb = 0;
        repeat (40) begin
            @(posedge fclk); #1;
            if (done_a) nd++;
            if (busy_a) nb++;
        end
        chk("abort no done", nd, 0);
        chk("abort no busy", nb, 0);

        // CLKDIV=1 instance
        run_xfer(1'b1, 8'h81, 8'hB6, -1, 1'b0, 1);
        check_xfer("div1", 8'h81, 8'hB6, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_spi.md
SD_SPI -- requirements
Module: sd_spi

Interface
REQ-001 SHALL have parameter CLKDIV, default 2, meaning the SD clock half-period in fclk cycles; the legal range is 1..255.
REQ-002 SHALL have port fclk, input, 1 bit: global FPGA clock; this is the only clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: one-fclk transfer request pulse, already resynchronised to fclk.
REQ-005 SHALL have port din, input, 8 bits: byte to transmit (0xFF on reads).
REQ-006 SHALL have port dout, output, 8 bits: last received byte.
REQ-007 SHALL have port busy, output, 1 bit: transfer in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port sdclk, output, 1 bit: SPI clock to the card.
REQ-010 SHALL have port sddo, output, 1 bit: MOSI.
REQ-011 SHALL have port sddi, input, 1 bit: MISO.
REQ-012 SHALL drive all outputs from registers, with no combinational path from any input to any output.

Function
REQ-013 SHALL implement SPI mode 0, MSB first, 8 bits per transfer, with sdclk idle at 0 and sddo idle at 1.
REQ-014 SHALL use a two-state FSM:
- IDLE -> SHIFT when start=1 at an edge.
- SHIFT -> IDLE at the edge that makes the 8th sdclk fall.
REQ-015 SHALL, on acceptance (IDLE, start=1):
- load the tx shift register with din;
- drive sddo=din[7] and busy=1 from the next cycle;
- clear the divider counter and the bit counter.
REQ-016 SHALL ignore start while in SHIFT: no restart, no queueing, din not re-sampled.
REQ-017 SHALL run the divider counter 0..CLKDIV-1 in SHIFT and toggle sdclk at each terminal count, so each sdclk phase lasts exactly CLKDIV fclk cycles.
REQ-018 SHALL, at each edge that drives sdclk 1->0:
- shift sddi into the rx register LSB;
- shift the tx register left, presenting the next bit on sddo;
- increment the 3-bit bit counter.
REQ-019 SHALL, at the edge of the 8th sdclk fall:
- copy the completed rx byte (including the sddi bit sampled at that edge) to dout;
- set busy=0, done=1 (for one cycle only) and sddo=1;
- return to IDLE.
REQ-020 SHALL keep busy high for exactly 16*CLKDIV fclk cycles per transfer.
REQ-021 SHALL hold dout stable during a transfer; dout changes only at completion.
REQ-022 SHALL accept a start arriving in the cycle where done=1, giving back-to-back transfers with a one-cycle IDLE gap.
REQ-023 SHALL keep sdclk=0 throughout IDLE and never produce a sdclk glitch or partial phase at a transfer boundary.

Reset
REQ-024 SHALL, when rst_n=0 is sampled at an fclk edge, set: state=IDLE, sdclk=0, sddo=1, busy=0, done=0, dout=8'hFF, and all counters and shift registers cleared (tx=8'hFF).
REQ-025 SHALL abort any transfer on reset, without a done pulse and without updating dout.
REQ-026 SHALL ignore start in any cycle where rst_n=0.

Verification
REQ-027 SHALL cover: CLKDIV=2, start with din=0xA5, slave returns 0x3C -> exactly 8 sdclk pulses, each 2 cycles high and 2 low; sddo=1,0,1,0,0,1,0,1 across the rises; busy high 32 cycles; done pulses once; dout=0x3C.
REQ-028 SHALL cover: start pulse at transfer cycle 5 with din=0x00 -> ignored; the transfer completes with the original MOSI data and exactly one done pulse.
REQ-029 SHALL cover: start in the done cycle with din=0xFF, sddi held 1 -> the second transfer begins the next cycle and dout=0xFF after 32 more cycles.
REQ-030 SHALL cover: rst_n=0 during the 4th bit with dout previously 0x3C -> the next edge gives sdclk=0, sddo=1, busy=0, no done pulse, dout=0xFF.
REQ-031 SHALL cover: CLKDIV=1, din=0x81 -> busy high 16 cycles, sdclk toggles every cycle, dout equals the sddi bit pattern applied.
